alu_op_sequencer: RTL and testbench

- Synthesizable initiator for the ALU array; it drives the same operand, select, flag and result bus that the ALU verification interface carries.
- Accepts one operation at a time on a valid/ready command channel and drives a, b and select into the ALU.
- Waits a fixed, parameterised ALU latency, then captures the result, carry and compare flags.
- Returns the captured result on a valid/ready response channel. It sits between the test/control logic and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 17 +
 rtl/alu_flag_checker.sv | 25 ++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer and its flag checker.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Bit positions within the {greater, equal, less} flag vector
    localparam int GT = 2;
    localparam int EQ = 1;
    localparam int LT = 0;

    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/alu_flag_checker.sv
// Combinational consistency check of ALU compare flags against an unsigned compare
// of the operands; used only when ALU_SEQ_FLAG_CHECK_EN is defined.
module alu_flag_checker
    import alu_seq_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [2:0]    flags,
    output logic          err
);

    logic [2:0] flags_exp;

    always_comb begin
        flags_exp     = 3'b000;
        flags_exp[GT] = (a > b);
        flags_exp[EQ] = (a == b);
        flags_exp[LT] = (a < b);
        // flags_exp is always one-hot, so a mismatch also catches non-one-hot flags
        err = !$onehot(flags) || (flags != flags_exp);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response sequencer for the ALU array: latches operands, waits ALU_LAT
// cycles, captures result and flags. Optional flag checker: ALU_SEQ_FLAG_CHECK_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int  WIDTH   = 4,
    parameter int  N_ALU   = 4,
    parameter int  ALU_LAT = 0,
    parameter int  OW      = WIDTH*N_ALU*8,
    localparam int AW      = WIDTH*N_ALU
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_a,
    input  logic [AW-1:0] cmd_b,
    input  logic [2:0]    cmd_sel,
    output logic [AW-1:0] alu_a,
    output logic [AW-1:0] alu_b,
    output logic [2:0]    alu_select,
    input  logic [OW-1:0] alu_out,
    input  logic          alu_carry_out,
    input  logic          alu_a_greater,
    input  logic          alu_a_equal,
    input  logic          alu_a_less,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [OW-1:0] rsp_out,
    output logic          rsp_carry,
    output logic [2:0]    rsp_flags,
    output logic          rsp_err,
    output logic          err_sticky,
    output logic [15:0]   txn_count
);

    // state | meaning
    // IDLE  | nothing in flight, ready for a command
    // WAIT  | operands on the ALU, latency counter running down
    // RESP  | result captured and offered on the response channel

    seq_state_t           state, state_nxt;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 accept;
    logic                 capture;
    logic                 rsp_hs;
    logic [2:0]           alu_flags;

    assign alu_flags = {alu_a_greater, alu_a_equal, alu_a_less};

    always_comb begin
        cmd_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
        rsp_valid = (state == RESP);
        accept    = cmd_valid && cmd_ready;
        capture   = (state == WAIT) && (cnt == '0);
        rsp_hs    = rsp_valid && rsp_ready;
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = accept ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            rsp_out    <= '0;
            rsp_carry  <= 1'b0;
            rsp_flags  <= '0;
            txn_count  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_select <= cmd_sel;
                cnt        <= LAT_CNT_W'(ALU_LAT);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_out   <= alu_out;
                rsp_carry <= alu_carry_out;
                rsp_flags <= alu_flags;
            end
            if (rsp_hs) txn_count <= txn_count + 16'd1;
        end
    end

`ifdef ALU_SEQ_FLAG_CHECK_EN
    logic chk_err;

    alu_flag_checker #(.AW(AW)) u_flag_checker (
        .a     (alu_a),
        .b     (alu_b),
        .flags (alu_flags),
        .err   (chk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else if (capture) begin
            rsp_err    <= chk_err;
            err_sticky <= err_sticky | chk_err;
        end
    end
`else
    assign rsp_err    = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: three instances (ALU_LAT 0, 2, 3)
// driven by directed vector tables and hand-written corner-case sequences.
module tb_alu_op_sequencer;

    localparam int AW = 16;
    localparam int OW = 128;
    localparam int N  = 3;

`ifdef ALU_SEQ_FLAG_CHECK_EN
    localparam logic FLAG_EN = 1'b1;
`else
    localparam logic FLAG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n       [N];
    logic          cmd_valid   [N];
    logic          cmd_ready   [N];
    logic [AW-1:0] cmd_a       [N];
    logic [AW-1:0] cmd_b       [N];
    logic [2:0]    cmd_sel     [N];
    logic [AW-1:0] alu_a       [N];
    logic [AW-1:0] alu_b       [N];
    logic [2:0]    alu_select  [N];
    logic [OW-1:0] alu_out     [N];
    logic          alu_carry   [N];
    logic          alu_gt      [N];
    logic          alu_eq      [N];
    logic          alu_lt      [N];
    logic          rsp_valid   [N];
    logic          rsp_ready   [N];
    logic [OW-1:0] rsp_out     [N];
    logic          rsp_carry   [N];
    logic [2:0]    rsp_flags   [N];
    logic          rsp_err     [N];
    logic          err_sticky  [N];
    logic [15:0]   txn_count   [N];
    logic [16:0]   alu_r       [N];
    logic          flag_ovr_en [N];
    logic [2:0]    flag_ovr    [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference ALU: 000 and, 001 add, 010 sub, 011 or, 100 xor, 101 not a, 110 a, 111 b
    function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] sel);
        case (sel)
            3'b000:  return {1'b0, a & b};
            3'b001:  return {1'b0, a} + {1'b0, b};
            3'b010:  return {1'b0, a} - {1'b0, b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            3'b101:  return {1'b0, ~a};
            3'b110:  return {1'b0, a};
            default: return {1'b0, b};
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign alu_r[g]     = alu_fn(alu_a[g], alu_b[g], alu_select[g]);
        assign alu_out[g]   = {{(OW-16){1'b0}}, alu_r[g][15:0]};
        assign alu_carry[g] = alu_r[g][16];
        assign {alu_gt[g], alu_eq[g], alu_lt[g]} = flag_ovr_en[g] ? flag_ovr[g] :
            {alu_a[g] > alu_b[g], alu_a[g] == alu_b[g], alu_a[g] < alu_b[g]};

        alu_op_sequencer #(
            .WIDTH   (4),
            .N_ALU   (4),
            .ALU_LAT ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .cmd_valid     (cmd_valid[g]),
            .cmd_ready     (cmd_ready[g]),
            .cmd_a         (cmd_a[g]),
            .cmd_b         (cmd_b[g]),
            .cmd_sel       (cmd_sel[g]),
            .alu_a         (alu_a[g]),
            .alu_b         (alu_b[g]),
            .alu_select    (alu_select[g]),
            .alu_out       (alu_out[g]),
            .alu_carry_out (alu_carry[g]),
            .alu_a_greater (alu_gt[g]),
            .alu_a_equal   (alu_eq[g]),
            .alu_a_less    (alu_lt[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_ready     (rsp_ready[g]),
            .rsp_out       (rsp_out[g]),
            .rsp_carry     (rsp_carry[g]),
            .rsp_flags     (rsp_flags[g]),
            .rsp_err       (rsp_err[g]),
            .err_sticky    (err_sticky[g]),
            .txn_count     (txn_count[g])
        );
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  sel;
        logic [15:0] out;
        logic        carry;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int i);
        chk($sformatf("rst%0d_cmd_ready", i), 128'(cmd_ready[i]), 128'd1);
        chk($sformatf("rst%0d_rsp_valid", i), 128'(rsp_valid[i]), 128'd0);
        chk($sformatf("rst%0d_alu_ops", i), {alu_a[i], alu_b[i], alu_select[i]}, 128'd0);
        chk($sformatf("rst%0d_rsp", i), {rsp_out[i][15:0], rsp_carry[i], rsp_flags[i]}, 128'd0);
        chk($sformatf("rst%0d_err", i), {rsp_err[i], err_sticky[i]}, 128'd0);
        chk($sformatf("rst%0d_txn_count", i), 128'(txn_count[i]), 128'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] sel);
        cmd_valid[i] = 1'b1;
        cmd_a[i]     = a;
        cmd_b[i]     = b;
        cmd_sel[i]   = sel;
        for (int k = 0; k < 50 && !cmd_ready[i]; k++) @(negedge clk);
        @(negedge clk);
        cmd_valid[i] = 1'b0;
    endtask

    // Edge count with the accept edge as edge 1
    task automatic wait_rsp(input int i, output int lat);
        lat = 1;
        while (!rsp_valid[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input int i);
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          n_acc;
        int          n_rsp;
        int          cyc;
        int          acc_cyc [4];
        logic        acc_now;
        logic        seen;
        logic [15:0] b2b_a   [4];
        logic [15:0] b2b_exp [4];

        vecs[0] = '{16'h0005, 16'h0003, 3'b001, 16'h0008, 1'b0, 3'b100};
        vecs[1] = '{16'hFFFF, 16'h0001, 3'b001, 16'h0000, 1'b1, 3'b100};
        vecs[2] = '{16'h0003, 16'h0005, 3'b010, 16'hFFFE, 1'b1, 3'b001};
        vecs[3] = '{16'h1234, 16'h1234, 3'b100, 16'h0000, 1'b0, 3'b010};
        vecs[4] = '{16'hF0F0, 16'h0FF0, 3'b000, 16'h00F0, 1'b0, 3'b100};
        vecs[5] = '{16'h00FF, 16'hFF00, 3'b011, 16'hFFFF, 1'b0, 3'b001};
        vecs[6] = '{16'h0000, 16'h0000, 3'b101, 16'hFFFF, 1'b0, 3'b010};
        vecs[7] = '{16'h8000, 16'h7FFF, 3'b111, 16'h7FFF, 1'b0, 3'b100};
        b2b_a   = '{16'h0001, 16'h1001, 16'h2001, 16'h3001};
        b2b_exp = '{16'h0011, 16'h1011, 16'h2011, 16'h3011};

        for (int i = 0; i < N; i++) begin
            rst_n[i]       = 1'b0;
            cmd_valid[i]   = 1'b0;
            cmd_a[i]       = '0;
            cmd_b[i]       = '0;
            cmd_sel[i]     = '0;
            rsp_ready[i]   = 1'b0;
            flag_ovr_en[i] = 1'b0;
            flag_ovr[i]    = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) chk_reset(i);
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        @(negedge clk);

        // Vector table on the combinational-ALU instance
        for (int v = 0; v < 8; v++) begin
            send(0, vecs[v].a, vecs[v].b, vecs[v].sel);
            wait_rsp(0, lat);
            chk($sformatf("v%0d_latency", v), 128'(lat), 128'd2);
            chk($sformatf("v%0d_rsp_out", v), rsp_out[0], {112'd0, vecs[v].out});
            chk($sformatf("v%0d_rsp_carry", v), 128'(rsp_carry[0]), 128'(vecs[v].carry));
            chk($sformatf("v%0d_rsp_flags", v), 128'(rsp_flags[0]), 128'(vecs[v].flags));
            chk($sformatf("v%0d_rsp_err", v), 128'(rsp_err[0]), 128'd0);
            handshake(0);
            chk($sformatf("v%0d_txn_count", v), 128'(txn_count[0]), 128'(v + 1));
            chk($sformatf("v%0d_alu_a_hold", v), 128'(alu_a[0]), 128'(vecs[v].a));
            chk($sformatf("v%0d_idle_ready", v), 128'(cmd_ready[0]), 128'd1);
        end

        // Counter wrap: preload near the top, then two transactions
        force g_dut[0].u_dut.txn_count = 16'hFFFE;
        @(negedge clk);
        release g_dut[0].u_dut.txn_count;
        chk("wrap_preload", 128'(txn_count[0]), 128'hFFFE);
        send(0, 16'h0001, 16'h0001, 3'b001);
        wait_rsp(0, lat);
        handshake(0);
        chk("wrap_ffff", 128'(txn_count[0]), 128'hFFFF);
        send(0, 16'h0001, 16'h0001, 3'b001);
        wait_rsp(0, lat);
        handshake(0);
        chk("wrap_zero", 128'(txn_count[0]), 128'h0000);

        // Inconsistent flags: equal operands reported as greater
        flag_ovr_en[0] = 1'b1;
        flag_ovr[0]    = 3'b100;
        send(0, 16'h0003, 16'h0003, 3'b001);
        wait_rsp(0, lat);
        chk("fc_bad_flags_raw", 128'(rsp_flags[0]), 128'b100);
        chk("fc_bad_rsp_out", rsp_out[0], 128'h6);
        chk("fc_bad_rsp_err", 128'(rsp_err[0]), 128'(FLAG_EN));
        chk("fc_bad_sticky", 128'(err_sticky[0]), 128'(FLAG_EN));
        handshake(0);
        chk("fc_sticky_after_hs", 128'(err_sticky[0]), 128'(FLAG_EN));
        flag_ovr_en[0] = 1'b0;
        send(0, 16'h0003, 16'h0003, 3'b001);
        wait_rsp(0, lat);
        chk("fc_good_flags", 128'(rsp_flags[0]), 128'b010);
        chk("fc_good_rsp_err", 128'(rsp_err[0]), 128'd0);
        chk("fc_good_sticky", 128'(err_sticky[0]), 128'(FLAG_EN));
        handshake(0);

        // Backpressure on ALU_LAT=2
        send(1, 16'h00A0, 16'h000B, 3'b010);
        wait_rsp(1, lat);
        chk("bp_latency", 128'(lat), 128'd4);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_rsp_valid", c), 128'(rsp_valid[1]), 128'd1);
            chk($sformatf("bp%0d_cmd_ready", c), 128'(cmd_ready[1]), 128'd0);
            chk($sformatf("bp%0d_rsp_out", c), rsp_out[1], 128'h95);
            chk($sformatf("bp%0d_rsp_flags", c), 128'(rsp_flags[1]), 128'b100);
            cmd_valid[1] = (c == 1);
            cmd_a[1]     = 16'h7777;
            @(negedge clk);
        end
        cmd_valid[1] = 1'b0;
        chk("bp_alu_a_kept", 128'(alu_a[1]), 128'h00A0);
        handshake(1);
        chk("bp_txn_count", 128'(txn_count[1]), 128'd1);
        chk("bp_idle_ready", 128'(cmd_ready[1]), 128'd1);

        // Back-to-back: four adds with cmd_valid and rsp_ready held high
        n_acc = 0;
        n_rsp = 0;
        cyc   = 0;
        cmd_a[1]     = b2b_a[0];
        cmd_b[1]     = 16'h0010;
        cmd_sel[1]   = 3'b001;
        cmd_valid[1] = 1'b1;
        rsp_ready[1] = 1'b1;
        while ((n_acc < 4 || n_rsp < 4) && cyc < 80) begin
            acc_now = cmd_valid[1] && cmd_ready[1];
            if (rsp_valid[1] && rsp_ready[1]) begin
                chk($sformatf("b2b%0d_rsp_out", n_rsp), rsp_out[1], {112'd0, b2b_exp[n_rsp]});
                n_rsp++;
            end
            if (acc_now) begin
                acc_cyc[n_acc] = cyc;
                if (n_acc > 0)
                    chk($sformatf("b2b%0d_overlap", n_acc), 128'(rsp_valid[1]), 128'd1);
                n_acc++;
            end
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                if (n_acc < 4) cmd_a[1] = b2b_a[n_acc];
                else cmd_valid[1] = 1'b0;
            end
        end
        rsp_ready[1] = 1'b0;
        chk("b2b_accepts", 128'(n_acc), 128'd4);
        chk("b2b_responses", 128'(n_rsp), 128'd4);
        for (int k = 1; k < 4; k++)
            chk($sformatf("b2b%0d_period", k), 128'(acc_cyc[k] - acc_cyc[k-1]), 128'd4);
        chk("b2b_txn_count", 128'(txn_count[1]), 128'd5);

        // Reset two cycles into WAIT on ALU_LAT=3
        send(2, 16'h0005, 16'h0003, 3'b001);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk_reset(2);
        repeat (2) @(negedge clk);
        rst_n[2]     = 1'b1;
        rsp_ready[2] = 1'b1;
        seen         = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid[2]) seen = 1'b1;
        end
        rsp_ready[2] = 1'b0;
        chk("rst_no_rsp", 128'(seen), 128'd0);
        chk("rst_txn_count", 128'(txn_count[2]), 128'd0);
        send(2, 16'h0005, 16'h0003, 3'b001);
        wait_rsp(2, lat);
        chk("lat3_latency", 128'(lat), 128'd5);
        chk("lat3_rsp_out", rsp_out[2], 128'h8);
        handshake(2);
        chk("lat3_txn_count", 128'(txn_count[2]), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
